// File: rtl/mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the mux select arbiter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int NUM_SRC = 3;

  typedef logic [1:0] src_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

  // One-hot select vector for a source index; unused code 3 maps to all-zero.
  function automatic logic [NUM_SRC-1:0] id_to_onehot(input src_id_t id);
    logic [NUM_SRC-1:0] oh;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_pick
// Combinational round-robin picker: first requester after last_id in the
// circular order 0 -> 1 -> 2 -> 0.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mux_rr_pick
  import mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  src_id_t            last_id,
  output src_id_t            pick_id,
  output logic               any_req
);

  src_id_t c0, c1, c2;

  // Build the search order starting just after last_id, then take the first hit.
  always_comb begin
    case (last_id)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    any_req = |req;
    if (req[c0])      pick_id = c0;
    else if (req[c1]) pick_id = c1;
    else if (req[c2]) pick_id = c2;
    else              pick_id = last_id;
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin select generator for a 3-input mux. Grants one source at a
// time, bounds contended turns to HOLD_CYCLES, and inserts a one-cycle
// all-zero guard between different grants. Selects are registered.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       grant_valid,
  output logic [1:0] grant_id
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t          state, state_nx;
  logic [CNT_W-1:0]    hold_cnt, hold_cnt_nx;
  src_id_t             last_id, last_id_nx;
  src_id_t             gid, gid_nx;
  logic [NUM_SRC-1:0]  sel, sel_nx;
  logic [NUM_SRC-1:0]  req;
  src_id_t             pick_id;
  logic                any_req;
  logic                granted_req;
  logic                others_req;

  assign req = {req3, req2, req1};

  // While in GRANT, last_id is the source currently holding the mux.
  assign granted_req = |(req & id_to_onehot(last_id));
  assign others_req  = |(req & ~id_to_onehot(last_id));

  mux_rr_pick u_pick (
    .req     (req),
    .last_id (last_id),
    .pick_id (pick_id),
    .any_req (any_req)
  );

  // Next-state, counter and next-select decode; selects default to all-zero.
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    last_id_nx  = last_id;
    gid_nx      = gid;
    sel_nx      = '0;
    case (state)
      IDLE, GUARD: begin
        if (any_req) begin
          state_nx    = GRANT;
          last_id_nx  = pick_id;
          gid_nx      = pick_id;
          hold_cnt_nx = HOLD_RELOAD;
          sel_nx      = id_to_onehot(pick_id);
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        if (!granted_req) begin
          state_nx = others_req ? GUARD : IDLE;
        end else if (hold_cnt != '0) begin
          hold_cnt_nx = hold_cnt - CNT_W'(1);
          sel_nx      = id_to_onehot(last_id);
        end else if (others_req) begin
          state_nx = GUARD;
        end else begin
          // Uncontended: keep the grant and start a fresh turn, no guard.
          hold_cnt_nx = HOLD_RELOAD;
          sel_nx      = id_to_onehot(last_id);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces selects low asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_id  <= 2'd2;
      gid      <= 2'd0;
      sel      <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
      last_id  <= last_id_nx;
      gid      <= gid_nx;
      sel      <= sel_nx;
    end
  end

  assign sel1        = sel[0];
  assign sel2        = sel[1];
  assign sel3        = sel[2];
  assign grant_valid = |sel;
  assign grant_id    = gid;

endmodule
`default_nettype wire

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin select generator that sits directly upstream of `mux` and drives its `sel1`/`sel2`/`sel3` inputs. Three sources request the shared 4-bit mux output. The block grants one at a time, holds each grant for a bounded number of cycles, and inserts a one-cycle all-zero guard between different sources (break-before-make). Its outputs are registered and connect 1:1 to the mux select pins.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles a grant is held before rotation is considered; legal range ≥1.
- `clk`  input  1  clock; all state updates on posedge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req1`  input  1  request from source 1 (drives `in1` of `mux`).
- `req2`  input  1  request from source 2.
- `req3`  input  1  request from source 3.
- `sel1`  output  1  registered select to `mux.sel1`.
- `sel2`  output  1  registered select to `mux.sel2`.
- `sel3`  output  1  registered select to `mux.sel3`.
- `grant_valid`  output  1  high exactly when one `selN` is high.
- `grant_id`  output  2  index of the granted source, 0..2; holds its last value when `grant_valid`=0.

## Operation
- FSM states: IDLE, GRANT, GUARD.
- Outputs are one-hot or all-zero at all times; two selects are never high together.
- Round-robin pick: the first requester after `last_id`, in circular order 0→1→2→0.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: pick → GRANT.
  - Set `last_id`=pick.
  - Load `hold_cnt`=HOLD_CYCLES-1.
- **GRANT**, checked in this priority order:
  - Granted request low, others pending → GUARD.
  - Granted request low, none pending → IDLE.
  - `hold_cnt`≠0 → decrement and stay in GRANT.
  - `hold_cnt`=0, another source requesting → GUARD.
  - `hold_cnt`=0, only the granted source requesting → stay in GRANT, reload `hold_cnt`, no guard.
- **GUARD** (always exactly 1 cycle, outputs all zero):
  - Any request: pick using req sampled at the GUARD edge → GRANT.
  - The pick may re-grant the same source if it is the only requester.
  - No request → IDLE.
- `hold_cnt` width is `$clog2(HOLD_CYCLES+1)`; it never wraps below 0.
- HOLD_CYCLES=1: rotation is re-evaluated every cycle; each switch still costs one GUARD cycle.

## Timing
- Reset (async assert, sync-safe deassert handled externally):
  - `sel1..3`=0, `grant_valid`=0, `grant_id`=0, state IDLE.
  - `last_id`=2, so the first grant after reset goes to source 0 when several request.
- Request-to-select latency is 1 cycle from IDLE: a request sampled at edge k gives `selN` high from edge k+1.
- Grant duration:
  - At most HOLD_CYCLES cycles per turn when contended.
  - Unbounded continuous hold when uncontended.
- Release latency: the granted request dropping at edge k gives `selN` low from edge k+1.
- Source switch: exactly one all-zero cycle between different grants.
- Reset mid-grant: selects drop immediately, without waiting for a clock.
- Requests are level-sensitive; no request latching occurs while a source is not granted.

## Structure
- Shared package `mux_pkg`:
  - `NUM_SRC`=3.
  - `typedef logic [1:0] src_id_t`.
  - `typedef enum logic [1:0] {IDLE, GRANT, GUARD} arb_state_t`.
- Sub-module `mux_rr_pick`: combinational; takes req[2:0] and last_id; returns pick_id and any_req.
- Top level holds the FSM, `hold_cnt`, `last_id` and the output registers.

## Test plan
All scenarios use HOLD_CYCLES=4, `mux` instantiated downstream, in1/in2/in3=4'b0001/0010/0100.
- **Single source:** req2 held high from cycle 0 → `sel2` high from cycle 1 continuously, no guard cycles, `grant_id`=1, `mux_op`=0010.
- **All three contending:** all req held → sel1 ×4, 000 ×1, sel2 ×4, 000 ×1, sel3 ×4, 000 ×1, sel1 …; `mux_op` follows 0001/0010/0100.
- **Early release:** req1 high, req3 high, req1 dropped after 2 granted cycles → sel1 ×2, 000 ×1, sel3.
- **Release with nothing pending:** req1 dropped alone → selects 000, state IDLE. A later req1 → sel1 one cycle after the sampled request, with no guard cycle.
- **Async reset mid-grant:** rst_n pulled low between edges during sel2 → selects 0 immediately. After release, with req1 and req2 both high, the first grant is sel1.
- **Invariant:** assertion on every cycle that `$countones({sel3,sel2,sel1})`≤1 and `grant_valid`==|{sel3,sel2,sel1}.
